// File: rtl/gt_tx_mmcm_reset_ctrl.sv
// Reset/lock sequencer for the GT TX user-clock MMCM. Holds the MMCM in reset until the TX path
// asks for clocks, then qualifies lock with a timeout, a settle window and bounded retries.
module gt_tx_mmcm_reset_ctrl #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1024,
  parameter int SETTLE_CYCLES       = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       mmcm_locked_i,
  output logic       mmcm_reset_o,
  output logic       usr_clk_ready_o,
  output logic       lock_lost_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_READY,
    ST_FAIL
  } state_t;

  localparam logic [15:0] RESET_LOAD   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LOAD = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        lost_d;
  logic        attempt_failed;
  logic        sync_meta_q, s_locked;

  // Valid/ready-free block: start_i is a level/pulse request honoured only in IDLE and FAIL;
  // every output is a registered decode of the next state so it moves on the same edge as the FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    retry_d        = retry_q;
    lost_d         = 1'b0;
    attempt_failed = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RESET;
          cnt_d   = RESET_LOAD;
          retry_d = 4'd0;
        end
      end
      ST_RESET: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (s_locked) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if (cnt_q == 16'd0) begin
          attempt_failed = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!s_locked) begin
          attempt_failed = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_READY;
          retry_d = 4'd0;
        end
      end
      ST_READY: begin
        // Lock loss starts a fresh sequence rather than consuming a retry.
        if (!s_locked) begin
          state_d = ST_RESET;
          cnt_d   = RESET_LOAD;
          lost_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        if (start_i) begin
          state_d = ST_RESET;
          cnt_d   = RESET_LOAD;
          retry_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (attempt_failed) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = ST_RESET;
        cnt_d   = RESET_LOAD;
      end else begin
        state_d = ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 16'd0;
      retry_q         <= 4'd0;
      sync_meta_q     <= 1'b0;
      s_locked        <= 1'b0;
      mmcm_reset_o    <= 1'b1;
      usr_clk_ready_o <= 1'b0;
      lock_lost_o     <= 1'b0;
      fail_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      sync_meta_q     <= mmcm_locked_i;
      s_locked        <= sync_meta_q;
      mmcm_reset_o    <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
      usr_clk_ready_o <= (state_d == ST_READY);
      lock_lost_o     <= lost_d;
      fail_o          <= (state_d == ST_FAIL);
    end
  end

  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_gt_tx_mmcm_reset_ctrl.sv
// Bench for gt_tx_mmcm_reset_ctrl: directed stimulus queues expected output changes with their
// edge number; a negedge monitor pops and compares each time the output vector changes.
module tb_gt_tx_mmcm_reset_ctrl;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  // clock / reset block
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       locked = 1'b0;
  logic       mmcm_reset, usr_ready, lock_lost, fail;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gt_tx_mmcm_reset_ctrl #(
    .RESET_CYCLES       (RC),
    .LOCK_TIMEOUT_CYCLES(LT),
    .SETTLE_CYCLES      (SC),
    .MAX_RETRIES        (MR)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .mmcm_locked_i  (locked),
    .mmcm_reset_o   (mmcm_reset),
    .usr_clk_ready_o(usr_ready),
    .lock_lost_o    (lock_lost),
    .fail_o         (fail),
    .retry_cnt_o    (retry_cnt)
  );

  // scoreboard: vector = {mmcm_reset, usr_ready, lock_lost, fail, retry_cnt}
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_v = 8'h00;
  logic [7:0] mon_v;
  int         mon_t;
  wire  [7:0] cur_v = {mmcm_reset, usr_ready, lock_lost, fail, retry_cnt};

  function automatic logic [7:0] v(input bit r, input bit rd, input bit l, input bit f,
                                   input int rc);
    return {r, rd, l, f, 4'(rc)};
  endfunction

  task automatic expect_at(input int t, input logic [7:0] e);
    exp_t_q.push_back(t);
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (cur_v !== prev_v) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur_v);
        end else begin
          mon_t = exp_t_q.pop_front();
          mon_v = exp_q.pop_front();
          if (mon_v !== cur_v || mon_t != cyc) begin
            n_errors++;
            $display("FAIL output_event got=%b at cyc %0d, exp=%b at cyc %0d",
                     cur_v, cyc, mon_v, mon_t);
          end
        end
      end else if (exp_q.size() != 0 && exp_t_q[0] < cyc) begin
        n_checks++;
        n_errors++;
        mon_t = exp_t_q.pop_front();
        mon_v = exp_q.pop_front();
        $display("FAIL missed_event got=%b at cyc %0d, exp=%b at cyc %0d",
                 cur_v, cyc, mon_v, mon_t);
      end
    end
    prev_v = cur_v;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "watchdog expired");
  end

  int c, n, w, f, m, m2;

  initial begin
    // reset state
    rst = 1'b1;
    wait_until(3);
    rst = 1'b0;
    wait_until(5);
    n_checks++;
    if (cur_v !== v(1, 0, 0, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_state got=%b exp=%b", cur_v, v(1, 0, 0, 0, 0));
    end
    mon_en = 1'b1;

    // nominal: 4-cycle reset, lock 10 cycles after release, ready 10+2+8 after release
    c = cyc; start = 1'b1; n = c + 1;
    expect_at(n + RC, v(0, 0, 0, 0, 0));
    wait_until(n); start = 1'b0;
    f = n + RC;
    wait_until(f + 9); locked = 1'b1;
    expect_at(f + 20, v(0, 1, 0, 0, 0));
    wait_until(f + 25);

    // lock loss in READY, then recovery
    c = cyc; locked = 1'b0; m = c + 1;
    expect_at(m + 2, v(1, 0, 1, 0, 0));
    expect_at(m + 3, v(1, 0, 0, 0, 0));
    expect_at(m + 6, v(0, 0, 0, 0, 0));
    wait_until(m + 8); locked = 1'b1; m2 = m + 9;
    expect_at(m2 + 2 + SC, v(0, 1, 0, 0, 0));
    wait_until(m2 + 14);

    // rst during READY, start held high while rst is asserted
    c = cyc; rst = 1'b1; start = 1'b1; locked = 1'b0;
    expect_at(c + 1, v(1, 0, 0, 0, 0));
    wait_until(c + 3); rst = 1'b0; start = 1'b0;
    wait_until(c + 10);

    // timeout on attempt 1, lock on attempt 2
    c = cyc; start = 1'b1; n = c + 1; w = n + RC;
    expect_at(w, v(0, 0, 0, 0, 0));
    expect_at(w + 32, v(1, 0, 0, 0, 1));
    expect_at(w + 36, v(0, 0, 0, 0, 1));
    wait_until(n); start = 1'b0;
    wait_until(w + 38); locked = 1'b1;
    expect_at(w + 49, v(0, 1, 0, 0, 0));
    wait_until(w + 55);

    c = cyc; rst = 1'b1; locked = 1'b0;
    expect_at(c + 1, v(1, 0, 0, 0, 0));
    wait_until(c + 2); rst = 1'b0;
    wait_until(c + 5);

    // exhaustion: three 4-cycle resets, FAIL after the third timeout
    c = cyc; start = 1'b1; n = c + 1; w = n + RC;
    expect_at(w, v(0, 0, 0, 0, 0));
    expect_at(w + 32, v(1, 0, 0, 0, 1));
    expect_at(w + 36, v(0, 0, 0, 0, 1));
    expect_at(w + 68, v(1, 0, 0, 0, 2));
    expect_at(w + 72, v(0, 0, 0, 0, 2));
    expect_at(w + 104, v(1, 0, 0, 1, 2));
    wait_until(n); start = 1'b0;
    wait_until(w + 115);

    // restart from FAIL clears retries
    c = cyc; start = 1'b1;
    expect_at(c + 1, v(1, 0, 0, 0, 0));
    expect_at(c + 5, v(0, 0, 0, 0, 0));
    wait_until(c + 1); start = 1'b0;

    // settle glitch: lock drops for one cycle inside SETTLE
    w = c + 5;
    expect_at(w + 10, v(1, 0, 0, 0, 1));
    expect_at(w + 14, v(0, 0, 0, 0, 1));
    expect_at(w + 23, v(0, 1, 0, 0, 0));
    wait_until(w); locked = 1'b1;
    wait_until(w + 7); locked = 1'b0;
    wait_until(w + 8); locked = 1'b1;
    wait_until(w + 28);

    // rst during WAIT_LOCK of the second attempt
    c = cyc; rst = 1'b1; locked = 1'b0;
    expect_at(c + 1, v(1, 0, 0, 0, 0));
    wait_until(c + 1); rst = 1'b0;
    c = cyc; start = 1'b1; n = c + 1; w = n + RC;
    expect_at(w, v(0, 0, 0, 0, 0));
    expect_at(w + 32, v(1, 0, 0, 0, 1));
    expect_at(w + 36, v(0, 0, 0, 0, 1));
    wait_until(n); start = 1'b0;
    wait_until(w + 41); rst = 1'b1; start = 1'b1;
    expect_at(w + 42, v(1, 0, 0, 0, 0));
    wait_until(w + 44); rst = 1'b0; start = 1'b0;
    wait_until(w + 60);

    // final report
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_events got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gt_tx_mmcm_reset_ctrl.md
# gt_tx_mmcm_reset_ctrl

Reset/lock sequencer for the GT TX user-clock MMCM: drives the MMCM reset input of the GT user-clock source and consumes its lock output. It holds the MMCM in reset until the GT TX path reports a valid TXOUTCLK, then releases reset and waits for lock with a timeout. It qualifies lock over a settle window and retries a bounded number of times. It then publishes a single "TX user clocks usable" flag to the GT TX reset FSM and datapath. It runs on the free-running system clock, never on a GT-derived clock.

## Interface

Parameters:
- RESET_CYCLES, 16: cycles mmcm_reset_o is held high per attempt (1..65535).
- LOCK_TIMEOUT_CYCLES, 1024: cycles allowed in WAIT_LOCK before an attempt fails (1..65535).
- SETTLE_CYCLES, 64: consecutive synchronized-locked cycles required before READY (1..65535).
- MAX_RETRIES, 3: extra attempts after the first before FAIL (0..15).

Ports:
- clk_i  in  1  free-running system clock.
- rst_i  in  1  reset: one clock, synchronous, active-high.
- start_i  in  1  level or pulse from the GT TX reset FSM: TXOUTCLK valid, begin sequence.
- mmcm_locked_i  in  1  MMCM lock from the user-clock source; asynchronous to clk_i.
- mmcm_reset_o  out  1  MMCM reset to the user-clock source, registered.
- usr_clk_ready_o  out  1  TX user clocks locked and settled, registered.
- lock_lost_o  out  1  one-cycle pulse: lock dropped while READY.
- fail_o  out  1  retries exhausted, sticky until rst_i or start_i.
- retry_cnt_o  out  4  retries consumed in the current sequence.

## Operation

- mmcm_locked_i passes through a 2-flop synchronizer. The FSM only sees the output of that synchronizer, called s_locked.
- There is one 16-bit down-counter shared by RESET, WAIT_LOCK and SETTLE. It is loaded on every state entry.
- States and transitions:
  - IDLE: start_i=1 → RESET. retry_cnt is cleared.
  - RESET: the counter is loaded with RESET_CYCLES-1. When it reaches 0 → WAIT_LOCK.
  - WAIT_LOCK: the counter is loaded with LOCK_TIMEOUT_CYCLES-1.
    - s_locked=1 → SETTLE. Lock takes priority over timeout in the same cycle.
    - Counter reaches 0 with no lock: if retry_cnt<MAX_RETRIES, retry_cnt++ and → RESET; otherwise → FAIL.
  - SETTLE: the counter is loaded with SETTLE_CYCLES-1.
    - s_locked=0 → the same retry decision as a WAIT_LOCK timeout.
    - Counter reaches 0 with s_locked still 1 → READY.
  - READY: retry_cnt is cleared on entry.
    - s_locked=0 → lock_lost_o pulses for 1 cycle and the FSM goes to RESET. retry_cnt is not incremented, so lock loss begins a fresh sequence.
  - FAIL: start_i=1 → clear retry_cnt and → RESET.
- start_i is ignored in RESET, WAIT_LOCK, SETTLE and READY.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - mmcm_reset_o is 1 in IDLE, RESET and FAIL, and 0 in WAIT_LOCK, SETTLE and READY.
  - usr_clk_ready_o is 1 only in READY.
  - fail_o is 1 only in FAIL.
- Reset values: state=IDLE, mmcm_reset_o=1, usr_clk_ready_o=0, lock_lost_o=0, fail_o=0, retry_cnt_o=0, synchronizer flops=0.
- rst_i asserted in any state returns the block to IDLE on the next edge. It overrides all other conditions. mmcm_reset_o is therefore re-asserted one edge after rst_i is sampled.

## Timing

- start_i sampled high at edge N:
  - RESET is entered and mmcm_reset_o=1 from edge N.
  - mmcm_reset_o stays high for exactly RESET_CYCLES cycles and falls at edge N+RESET_CYCLES.
- Lock latency: a rising mmcm_locked_i that is stable before edge M gives s_locked=1 after edge M+1. The FSM enters SETTLE at edge M+2.
- From entering SETTLE, usr_clk_ready_o rises exactly SETTLE_CYCLES edges later, provided s_locked holds.
- A WAIT_LOCK timeout occurs LOCK_TIMEOUT_CYCLES edges after WAIT_LOCK entry. The next RESET begins on that edge.
- Lock drop while READY: mmcm_locked_i falls before edge M.
  - usr_clk_ready_o falls and lock_lost_o=1 at edge M+2.
  - lock_lost_o returns to 0 at edge M+3.
  - mmcm_reset_o=1 from edge M+2.
- Minimum time from start_i to ready: RESET_CYCLES + 2 + SETTLE_CYCLES cycles, assuming lock is already asserted when reset releases.

## Test plan

Use RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, SETTLE_CYCLES=8, MAX_RETRIES=2.

1. Nominal:
   - Stimulus: pulse start_i; the model raises lock 10 cycles after mmcm_reset_o falls.
   - Required: mmcm_reset_o high for exactly 4 cycles; usr_clk_ready_o rises 10+2+8 cycles after the reset falls; retry_cnt_o=0.
2. Timeout then recover:
   - Stimulus: no lock on attempt 1; lock on attempt 2.
   - Required: mmcm_reset_o re-asserts 32 cycles after the first release; retry_cnt_o=1 during attempt 2; cleared to 0 on READY.
3. Exhaustion:
   - Stimulus: lock never asserted.
   - Required: three reset pulses of 4 cycles each; fail_o=1 after the third timeout; retry_cnt_o=2; mmcm_reset_o held 1; a later start_i restarts with retry_cnt_o=0.
4. Settle glitch:
   - Stimulus: lock high for 5 cycles in SETTLE, then low for 1 cycle.
   - Required: the FSM goes to RESET; retry_cnt_o increments; usr_clk_ready_o never asserts during the glitch.
5. Lock loss in READY:
   - Stimulus: drop mmcm_locked_i.
   - Required: lock_lost_o is a single-cycle pulse 2 edges later; usr_clk_ready_o falls on that same edge; a new 4-cycle reset follows; READY is re-reached when lock returns.
6. Mid-operation reset:
   - Stimulus: assert rst_i during WAIT_LOCK and during READY.
   - Required: all outputs take their reset values on the next edge; start_i is ignored while rst_i=1.
